// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings (also used by the receiver) and line constants.
package uart_pkg;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_CLKS_PER_BIT_DEFAULT = 10416;  // 100 MHz / 9600 baud

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_STOP    = 3'd3,
        ST_CLEANUP = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_transmitter_if.sv
// Producer-side bundle of the UART transmitter: byte write handshake plus line status.
interface uart_transmitter_if;
    import uart_pkg::*;

    logic                      i_Tx_DV;
    logic [UART_DATA_BITS-1:0] i_Tx_Byte;
    logic                      o_Tx_Ready;
    logic                      o_Tx_Serial;
    logic                      o_Tx_Active;
    logic                      o_Tx_Done;

    modport master (
        output i_Tx_DV,
        output i_Tx_Byte,
        input  o_Tx_Ready,
        input  o_Tx_Serial,
        input  o_Tx_Active,
        input  o_Tx_Done
    );

    modport slave (
        input  i_Tx_DV,
        input  i_Tx_Byte,
        output o_Tx_Ready,
        output o_Tx_Serial,
        output o_Tx_Active,
        output o_Tx_Done
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with first-word fall-through read; full pushes and empty pops are ignored.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     i_Clock,
    input  logic                     i_Reset,
    input  logic                     i_Push,
    input  logic [WIDTH-1:0]         i_Data,
    input  logic                     i_Pop,
    output logic [WIDTH-1:0]         o_Data,
    output logic                     o_Full,
    output logic                     o_Empty,
    output logic [$clog2(DEPTH):0]   o_Count
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW-1:0]   PTR_LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
    localparam logic [AW:0]     CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]     CNT_ONE  = (AW + 1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] ptr);
        return (ptr == PTR_LAST) ? '0 : ptr + PTR_ONE;
    endfunction

    assign o_Full    = (r_count == CNT_FULL);
    assign o_Empty   = (r_count == '0);
    assign o_Count   = r_count;
    assign o_Data    = r_mem[r_rd_ptr];
    assign w_push_ok = i_Push && !o_Full;
    assign w_pop_ok  = i_Pop && !o_Empty;

    // NOTE: the storage array has no reset; count and pointers alone decide which entries are valid.
    always_ff @(posedge i_Clock) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_Data;
    end

    // NOTE: clocked state uses <= so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= ptr_next(r_wr_ptr);
            if (w_pop_ok)  r_rd_ptr <= ptr_next(r_rd_ptr);
            if (w_push_ok && !w_pop_ok)      r_count <= r_count + CNT_ONE;
            else if (!w_push_ok && w_pop_ok) r_count <= r_count - CNT_ONE;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: FIFO-buffered bytes are shifted out LSB first, each bit CLKS_PER_BIT clocks wide.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    uart_transmitter_if.slave tx_bus
);

    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam int            FW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [FW-1:0] FIFO_FULL = FW'(FIFO_DEPTH);
    localparam logic [2:0]    LAST_BIT  = 3'(UART_DATA_BITS - 1);

    uart_state_e               r_state;
    uart_state_e               w_next_state;
    logic [CW-1:0]             r_clk_cnt;
    logic [2:0]                r_bit_idx;
    logic [2:0]                w_bit_idx_inc;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic                      r_serial;
    logic                      r_done;
    logic                      w_cnt_last;
    logic                      w_pop;
    logic                      w_active;
    logic                      w_ready;
    logic                      w_push;
    logic                      w_fifo_full;
    logic                      w_fifo_empty;
    logic [FW-1:0]             w_fifo_count;
    logic [UART_DATA_BITS-1:0] w_fifo_data;

    assign w_ready       = (w_fifo_count != FIFO_FULL);
    assign w_push        = tx_bus.i_Tx_DV && !w_fifo_full;
    assign w_cnt_last    = (r_clk_cnt == CNT_LAST);
    assign w_bit_idx_inc = r_bit_idx + 3'd1;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .i_Push  (w_push),
        .i_Data  (tx_bus.i_Tx_Byte),
        .i_Pop   (w_pop),
        .o_Data  (w_fifo_data),
        .o_Full  (w_fifo_full),
        .o_Empty (w_fifo_empty),
        .o_Count (w_fifo_count)
    );

    always_ff @(posedge i_Clock) begin
        if (i_Reset) r_state <= ST_IDLE;
        else         r_state <= w_next_state;
    end

    // NOTE: default assignment first so no path through the case leaves the signal unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:    if (!w_fifo_empty) w_next_state = ST_START;
            ST_START:   if (w_cnt_last) w_next_state = ST_DATA;
            ST_DATA:    if (w_cnt_last && (r_bit_idx == LAST_BIT)) w_next_state = ST_STOP;
            ST_STOP:    if (w_cnt_last) w_next_state = ST_CLEANUP;
            ST_CLEANUP: w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_pop    = 1'b0;
        w_active = 1'b0;
        case (r_state)
            ST_IDLE:                   w_pop    = !w_fifo_empty;
            ST_START, ST_DATA, ST_STOP: w_active = 1'b1;
            default:                   ;
        endcase
    end

    // Line, bit timing and shift register; the shift register loads only at the IDLE pop.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_serial  <= 1'b1;
            r_done    <= 1'b0;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_serial  <= 1'b1;
                    r_clk_cnt <= '0;
                    if (w_pop) begin
                        r_shift  <= w_fifo_data;
                        r_serial <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_cnt_last) begin
                        r_serial  <= r_shift[0];
                        r_bit_idx <= '0;
                        r_clk_cnt <= '0;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (w_cnt_last) begin
                        r_clk_cnt <= '0;
                        if (r_bit_idx == LAST_BIT) begin
                            r_serial <= 1'b1;
                        end else begin
                            r_bit_idx <= w_bit_idx_inc;
                            r_serial  <= r_shift[w_bit_idx_inc];
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_ONE;
                    end
                end
                ST_STOP: begin
                    if (w_cnt_last) begin
                        r_done    <= 1'b1;
                        r_clk_cnt <= '0;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_ONE;
                    end
                end
                ST_CLEANUP: r_clk_cnt <= '0;
                default: begin
                    r_serial  <= 1'b1;
                    r_clk_cnt <= '0;
                end
            endcase
        end
    end

    assign tx_bus.o_Tx_Ready  = w_ready;
    assign tx_bus.o_Tx_Serial = r_serial;
    assign tx_bus.o_Tx_Active = w_active;
    assign tx_bus.o_Tx_Done   = r_done;

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench for uart_transmitter: a driver queues expected bytes, a line monitor decodes frames and compares.
module tb_uart_transmitter;

    localparam int CPB        = 4;
    localparam int DEPTH      = 4;
    localparam int FRAME_BITS = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_transmitter_if tx ();

    uart_transmitter #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .i_Clock (clk),
        .i_Reset (rst),
        .tx_bus  (tx)
    );

    always #5 clk = ~clk;

    int         checks      = 0;
    int         errors      = 0;
    int         frames_done = 0;
    logic [7:0] pending[$];      // bytes accepted by the transmitter but not yet started on the line
    bit         rst_event   = 1'b0;
    bit         in_frame    = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // One write strobe; acceptance is predicted from the model's occupancy, not read from the DUT.
    task automatic push_byte(input logic [7:0] b);
        @(negedge clk);
        #1;
        check("tx_ready", tx.o_Tx_Ready, (pending.size() < DEPTH));
        if (pending.size() < DEPTH) pending.push_back(b);
        tx.i_Tx_DV   = 1'b1;
        tx.i_Tx_Byte = b;
        @(posedge clk);
        #1;
        tx.i_Tx_DV = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #1;
        rst       = 1'b1;
        rst_event = 1'b1;
        pending.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((pending.size() != 0 || in_frame) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", (n < 5000), 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_line_low();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx.o_Tx_Serial !== 1'b0 && n < 500);
        check("line_low_timeout", (n < 500), 1);
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx.o_Tx_Done !== 1'b1 && n < 500);
        check("done_timeout", (n < 500), 1);
    endtask

    // Called on the first negedge of a start bit; samples every clock of the frame.
    task automatic mon_frame(output bit aborted, output bit chain);
        logic [7:0] exp;
        logic [7:0] got;
        logic       exp_bit;
        int         pos;
        int         bad      = 0;
        int         act_bad  = 0;
        int         done_bad = 0;
        aborted  = 1'b0;
        chain    = 1'b0;
        got      = '0;
        in_frame = 1'b1;
        check("frame_expected", (pending.size() != 0), 1);
        exp = (pending.size() != 0) ? pending.pop_front() : 8'h00;
        for (int s = 0; s < FRAME_BITS * CPB; s++) begin
            if (s != 0) begin
                @(negedge clk);
                if (rst_event) begin aborted = 1'b1; return; end
            end
            pos     = s / CPB;
            exp_bit = (pos == 0) ? 1'b0 : (pos == FRAME_BITS - 1) ? 1'b1 : exp[pos-1];
            if (tx.o_Tx_Serial !== exp_bit) bad++;
            if (pos >= 1 && pos <= 8 && (s % CPB) == CPB / 2) got[pos-1] = tx.o_Tx_Serial;
            if (tx.o_Tx_Active !== 1'b1) act_bad++;
            if (tx.o_Tx_Done !== 1'b0) done_bad++;
        end
        @(negedge clk);
        if (rst_event) begin aborted = 1'b1; return; end
        check("done_pulse", {tx.o_Tx_Done, tx.o_Tx_Active, tx.o_Tx_Serial}, 3'b101);
        @(negedge clk);
        if (rst_event) begin aborted = 1'b1; return; end
        check("done_width", {tx.o_Tx_Done, tx.o_Tx_Active, tx.o_Tx_Serial}, 3'b001);
        check("frame_byte", got, exp);
        check("bit_timing", bad, 0);
        check("active_span", act_bad, 0);
        check("done_quiet", done_bad, 0);
        frames_done++;
        if (pending.size() != 0) begin
            @(negedge clk);
            if (rst_event) begin aborted = 1'b1; return; end
            check("frame_gap", tx.o_Tx_Serial, 0);
            chain = (tx.o_Tx_Serial === 1'b0);
        end
        in_frame = chain;
    endtask

    initial begin : monitor
        bit aborted;
        bit chain;
        forever begin
            @(negedge clk);
            if (rst_event) begin
                rst_event = 1'b0;
                in_frame  = 1'b0;
                check("reset_line_high", tx.o_Tx_Serial, 1);
            end else if (tx.o_Tx_Serial === 1'b0) begin
                chain = 1'b1;
                while (chain) begin
                    mon_frame(aborted, chain);
                    if (aborted) begin
                        rst_event = 1'b0;
                        in_frame  = 1'b0;
                        chain     = 1'b0;
                        check("reset_line_high", tx.o_Tx_Serial, 1);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        errors++;
        checks++;
        $display("FAIL watchdog: got no completion, expected finish within time limit");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [7:0] loop_bytes[4];
        int         viol;
        loop_bytes   = '{8'h00, 8'hFF, 8'h55, 8'h80};
        tx.i_Tx_DV   = 1'b0;
        tx.i_Tx_Byte = 8'h00;
        rst          = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_serial", tx.o_Tx_Serial, 1);
        check("reset_active", tx.o_Tx_Active, 0);
        check("reset_done", tx.o_Tx_Done, 0);
        check("reset_ready", tx.o_Tx_Ready, 1);

        // Single byte and start latency
        push_byte(8'hA5);
        @(negedge clk);
        check("latency_idle", {tx.o_Tx_Active, tx.o_Tx_Serial}, 2'b01);
        @(negedge clk);
        check("latency_start", {tx.o_Tx_Active, tx.o_Tx_Serial}, 2'b10);
        wait_idle();

        // Decoded back-to-back bytes
        foreach (loop_bytes[i]) push_byte(loop_bytes[i]);
        wait_idle();

        // Burst while busy: fifth push finds the FIFO full
        push_byte(8'h11);
        wait_line_low();
        for (int i = 0; i < 5; i++) push_byte(8'(8'h20 + i));
        wait_idle();

        // Push mid-DATA must not disturb the byte on the line
        push_byte(8'hC3);
        wait_line_low();
        repeat (CPB + 2 * CPB) @(negedge clk);
        push_byte(8'h3C);
        wait_idle();

        // Reset during a frame with two bytes queued
        push_byte(8'h96);
        push_byte(8'h69);
        push_byte(8'hF0);
        wait_line_low();
        repeat (CPB + 3 * CPB + 1) @(negedge clk);
        pulse_reset();
        @(negedge clk);
        #1;
        check("reset_mid_ready", tx.o_Tx_Ready, 1);
        viol = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx.o_Tx_Serial !== 1'b1 || tx.o_Tx_Done !== 1'b0 || tx.o_Tx_Active !== 1'b0) viol++;
        end
        check("reset_quiet", viol, 0);
        wait_idle();

        // Push coinciding with the pop while three bytes wait
        push_byte(8'h5A);
        wait_line_low();
        push_byte(8'h81);
        push_byte(8'h42);
        push_byte(8'h24);
        wait_done();
        push_byte(8'hE7);
        push_byte(8'h7E);
        push_byte(8'hBD);
        wait_idle();

        // Randomised traffic with random idle gaps
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 50)) @(posedge clk);
            push_byte(8'($urandom));
        end
        wait_idle();

        check("frames_seen", (frames_done > 40), 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
